game_mode_ctrl: RTL and testbench
=================================

GAME_MODE_CTRL -- requirements
Module: game_mode_ctrl

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 1_000_000, is the number of consecutive stable cycles before a button level is accepted.
REQ-002 Parameter GAP_CYCLES, default 16, is the number of all-modes-inactive cycles inserted on every mode switch.
REQ-003 clk  input  1  system clock, 100 MHz.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 btn_mode_raw  input  1  raw mode-select button.
REQ-006 btn_go_raw  input  1  raw go/stop button.
REQ-007 mode_led  input  64  LED vectors of modes 0..3; mode n occupies bits [16n+15:16n].
REQ-008 mode_seg  input  80  seg_data of modes 0..3; mode n occupies bits [20n+19:20n].
REQ-009 mode_dp  input  16  dp_data of modes 0..3; mode n occupies bits [4n+3:4n].
REQ-010 mode_win  input  4  per-mode level, high while that mode is in its WIN state.
REQ-011 active  output  4  one-hot enable to the mode blocks; all zero when no mode runs.
REQ-012 btn_go_stop  output  1  debounced go/stop level, forwarded to the running mode.
REQ-013 led  output  16  board LEDs.
REQ-014 seg_data  output  20  four 5-bit character codes for the display, digit 3 in the MSBs.
REQ-015 dp_data  output  4  display decimal points.
REQ-016 cur_mode  output  2  selected mode index.

Function
REQ-017 Each raw button SHALL pass through a 2-flop synchronizer and then a debouncer.
REQ-018 Debouncer: the debounced level SHALL change only after the synchronized input differs from it for DEBOUNCE_CYCLES consecutive cycles.
REQ-019 A rising edge of a debounced level SHALL produce a 1-cycle pulse (mode_edge, go_edge).
REQ-020 The FSM SHALL have the states MENU, GAP and PLAY.
REQ-021 MENU: active=0; btn_go_stop=0; led=0; dp_data=0; seg_data={C_HYPHEN, digit(cur_mode+1), C_HYPHEN, C_BLANK}, with C_HYPHEN=10, C_BLANK=31 and digits 0-9 as codes 0-9.
REQ-022 MENU, mode_edge: cur_mode SHALL increment, wrapping 3->0.
REQ-023 MENU, go_edge with no mode_edge: the FSM SHALL go to GAP and the gap counter SHALL load to 0.
REQ-024 MENU, mode_edge and go_edge in the same cycle: mode_edge SHALL win, cur_mode increments and the state stays MENU.
REQ-025 GAP: active=0 and the outputs SHALL hold the MENU display for GAP_CYCLES cycles; the FSM then enters PLAY.
REQ-026 GAP entry SHALL clear any mode block before it starts.
REQ-027 PLAY: active SHALL be one-hot at bit cur_mode.
REQ-028 PLAY: led, seg_data and dp_data SHALL be registered copies of the selected mode's slices, one cycle of latency.
REQ-029 PLAY: btn_go_stop SHALL equal the debounced go level.
REQ-030 PLAY, mode_edge: the FSM SHALL go to MENU; active SHALL drop on the next cycle and btn_go_stop SHALL be 0 from that cycle.
REQ-031 PLAY: go_edge SHALL NOT change the controller state.
REQ-032 Inputs of non-selected modes SHALL be ignored in all states.

Reset
REQ-033 Asserting reset, including mid-GAP or mid-PLAY, SHALL immediately set: state=MENU, cur_mode=0, active=0, btn_go_stop=0, led=0, seg_data={10,10,10,10}, dp_data=0, debounced levels=0, counters=0.
REQ-034 After reset deassertion, the first clock SHALL show the MENU display for mode 1.

Configuration
REQ-035 With WIN_TALLY_EN defined: a 4-bit win counter per mode SHALL increment on each rising edge of mode_win[cur_mode] in PLAY.
REQ-036 With WIN_TALLY_EN defined: the counter SHALL saturate at 9 and clear only on reset.
REQ-037 With WIN_TALLY_EN defined: MENU digit 0 SHALL show that mode's tally instead of C_BLANK.
REQ-038 Without WIN_TALLY_EN: no counters SHALL be built, mode_win SHALL be unused, and MENU digit 0 SHALL be C_BLANK.

Verification (bench uses DEBOUNCE_CYCLES=4, GAP_CYCLES=3)
REQ-039 Debounce: btn_mode_raw pulsed high for 3 cycles -> cur_mode stays 0; held 10 cycles -> cur_mode=1; seg_data={10,2,10,31}.
REQ-040 Mode wrap: 4 accepted mode presses from reset -> cur_mode 1,2,3,0.
REQ-041 Start: cur_mode=2, then go press -> active=0 for exactly 3 cycles, then active=4'b0100; led follows mode_led[47:32] one cycle later.
REQ-042 Simultaneous: mode and go debounced edges in the same MENU cycle -> cur_mode increments, state stays MENU, active stays 0.
REQ-043 Abort: reset asserted mid-PLAY -> active=0 and seg_data={10,10,10,10} without a clock edge.
REQ-044 Tally (WIN_TALLY_EN): 11 mode_win[0] rising edges in PLAY, then return to MENU -> seg_data={10,1,10,9}.

Source files
------------

// File: rtl/game_mode_ctrl.sv
`default_nettype none
// =====================================================================
// game_mode_ctrl : debounced menu/launch controller for four game modes
// Build option   : WIN_TALLY_EN adds per-mode win tallies (menu digit 0)
// Revision       : 1.0
// =====================================================================
module game_mode_ctrl #(
  parameter int DEBOUNCE_CYCLES = 1_000_000,
  parameter int GAP_CYCLES      = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        btn_mode_raw,
  input  logic        btn_go_raw,
  input  logic [63:0] mode_led,
  input  logic [79:0] mode_seg,
  input  logic [15:0] mode_dp,
  input  logic [3:0]  mode_win,
  output logic [3:0]  active,
  output logic        btn_go_stop,
  output logic [15:0] led,
  output logic [19:0] seg_data,
  output logic [3:0]  dp_data,
  output logic [1:0]  cur_mode
);

  localparam int C_DB_W  = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int C_GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [C_DB_W-1:0]  C_DB_LAST  = C_DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [C_DB_W-1:0]  C_DB_ONE   = C_DB_W'(1);
  localparam logic [C_GAP_W-1:0] C_GAP_LAST = C_GAP_W'(GAP_CYCLES - 1);
  localparam logic [C_GAP_W-1:0] C_GAP_ONE  = C_GAP_W'(1);

  localparam logic [4:0]  C_HYPHEN    = 5'd10;
  localparam logic [4:0]  C_BLANK     = 5'd31;
  localparam logic [19:0] C_SEG_RESET = {C_HYPHEN, C_HYPHEN, C_HYPHEN, C_HYPHEN};

  localparam logic [1:0] S_MENU = 2'd0;
  localparam logic [1:0] S_GAP  = 2'd1;
  localparam logic [1:0] S_PLAY = 2'd2;

  logic [1:0]         state_q, state_d;
  logic [1:0]         cur_mode_q, cur_mode_d;
  logic [C_GAP_W-1:0] gap_cnt_q, gap_cnt_d;
  logic [15:0]        led_q, led_d;
  logic [19:0]        seg_q, seg_d;
  logic [3:0]         dp_q, dp_d;

  logic [1:0] w_raw;
  logic [1:0] w_edge;
  logic       w_go_level;
  logic       w_mode_edge;
  logic       w_go_edge;
  logic [4:0] w_mode_num;
  logic [4:0] w_digit0;
  logic [19:0] w_menu_seg;

  assign w_raw = {btn_go_raw, btn_mode_raw};

  // Bit 0 is the mode button, bit 1 the go/stop button.
  for (genvar gi = 0; gi < 2; gi++) begin : g_btn
    logic              sync1_q;
    logic              sync2_q;
    logic              deb_q;
    logic              deb_prev_q;
    logic [C_DB_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        sync1_q    <= 1'b0;
        sync2_q    <= 1'b0;
        deb_q      <= 1'b0;
        deb_prev_q <= 1'b0;
        cnt_q      <= '0;
      end else begin
        sync1_q    <= w_raw[gi];
        sync2_q    <= sync1_q;
        deb_prev_q <= deb_q;
        if (sync2_q == deb_q) begin
          cnt_q <= '0;
        end else if (cnt_q == C_DB_LAST) begin
          deb_q <= sync2_q;
          cnt_q <= '0;
        end else begin
          cnt_q <= cnt_q + C_DB_ONE;
        end
      end
    end

    assign w_edge[gi] = deb_q & ~deb_prev_q;
  end

  assign w_go_level  = g_btn[1].deb_q;
  assign w_mode_edge = w_edge[0];
  assign w_go_edge   = w_edge[1];

`ifdef WIN_TALLY_EN
  logic [3:0] tally_q [4];
  logic       win_prev_q;
  logic       w_win_rise;

  assign w_win_rise = mode_win[cur_mode_q] & ~win_prev_q;

  // Tallies saturate at 9 so they always fit one decimal digit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      win_prev_q <= 1'b0;
      for (int i = 0; i < 4; i++) begin
        tally_q[i] <= 4'd0;
      end
    end else begin
      win_prev_q <= mode_win[cur_mode_q];
      if ((state_q == S_PLAY) && w_win_rise && (tally_q[cur_mode_q] != 4'd9)) begin
        tally_q[cur_mode_q] <= tally_q[cur_mode_q] + 4'd1;
      end
    end
  end

  assign w_digit0 = {1'b0, tally_q[cur_mode_q]};
`else
  logic w_unused_win;
  assign w_unused_win = ^mode_win;
  assign w_digit0     = C_BLANK;
`endif

  assign w_mode_num = {3'b000, cur_mode_q} + 5'd1;
  assign w_menu_seg = {C_HYPHEN, w_mode_num, C_HYPHEN, w_digit0};

  always_comb begin
    state_d    = state_q;
    cur_mode_d = cur_mode_q;
    gap_cnt_d  = gap_cnt_q;
    case (state_q)
      S_MENU: begin
        // Mode press takes priority over a coincident go press.
        if (w_mode_edge) begin
          cur_mode_d = cur_mode_q + 2'd1;
        end else if (w_go_edge) begin
          state_d   = S_GAP;
          gap_cnt_d = '0;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == C_GAP_LAST) begin
          state_d = S_PLAY;
        end else begin
          gap_cnt_d = gap_cnt_q + C_GAP_ONE;
        end
      end
      S_PLAY: begin
        if (w_mode_edge) begin
          state_d = S_MENU;
        end
      end
      default: begin
        state_d = S_MENU;
      end
    endcase
  end

  always_comb begin
    led_d = 16'h0000;
    seg_d = w_menu_seg;
    dp_d  = 4'h0;
    if (state_q == S_PLAY) begin
      led_d = mode_led[{cur_mode_q, 4'b0000} +: 16];
      seg_d = mode_seg[20 * cur_mode_q +: 20];
      dp_d  = mode_dp[{cur_mode_q, 2'b00} +: 4];
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= S_MENU;
      cur_mode_q <= 2'd0;
      gap_cnt_q  <= '0;
      led_q      <= 16'h0000;
      seg_q      <= C_SEG_RESET;
      dp_q       <= 4'h0;
    end else begin
      state_q    <= state_d;
      cur_mode_q <= cur_mode_d;
      gap_cnt_q  <= gap_cnt_d;
      led_q      <= led_d;
      seg_q      <= seg_d;
      dp_q       <= dp_d;
    end
  end

  // Mode blocks are held cleared whenever they are not the running mode.
  assign active      = (state_q == S_PLAY) ? (4'b0001 << cur_mode_q) : 4'b0000;
  assign btn_go_stop = (state_q == S_PLAY) & w_go_level;
  assign led         = led_q;
  assign seg_data    = seg_q;
  assign dp_data     = dp_q;
  assign cur_mode    = cur_mode_q;

endmodule
`default_nettype wire

// File: tb/tb_game_mode_ctrl.sv
`default_nettype none
// =====================================================================
// tb_game_mode_ctrl : directed self-checking bench for game_mode_ctrl
// Revision          : 1.0
// =====================================================================
module tb_game_mode_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        btn_mode_raw;
  logic        btn_go_raw;
  logic [63:0] mode_led;
  logic [79:0] mode_seg;
  logic [15:0] mode_dp;
  logic [3:0]  mode_win;
  logic [3:0]  active;
  logic        btn_go_stop;
  logic [15:0] led;
  logic [19:0] seg_data;
  logic [3:0]  dp_data;
  logic [1:0]  cur_mode;

  int n_checks = 0;
  int n_pass   = 0;

  game_mode_ctrl #(
    .DEBOUNCE_CYCLES (4),
    .GAP_CYCLES      (3)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .btn_mode_raw (btn_mode_raw),
    .btn_go_raw   (btn_go_raw),
    .mode_led     (mode_led),
    .mode_seg     (mode_seg),
    .mode_dp      (mode_dp),
    .mode_win     (mode_win),
    .active       (active),
    .btn_go_stop  (btn_go_stop),
    .led          (led),
    .seg_data     (seg_data),
    .dp_data      (dp_data),
    .cur_mode     (cur_mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [19:0] seg4(input logic [4:0] d3, input logic [4:0] d2,
                                       input logic [4:0] d1, input logic [4:0] d0);
    return {d3, d2, d1, d0};
  endfunction

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic press_mode();
    btn_mode_raw = 1'b1;
    cyc(10);
    btn_mode_raw = 1'b0;
    cyc(10);
  endtask

  initial begin
    reset        = 1'b0;
    btn_mode_raw = 1'b0;
    btn_go_raw   = 1'b0;
    mode_win     = 4'h0;
    mode_led     = {16'hF00F, 16'hA5C3, 16'h1234, 16'h0F0F};
    mode_seg     = {20'h00003, 20'hABCDE, 20'h12345, 20'h54321};
    mode_dp      = 16'h8421;

    #1 reset = 1'b1;
    #1;
    check("rst_active",   active,      4'h0);
    check("rst_go",       btn_go_stop, 1'b0);
    check("rst_led",      led,         16'h0000);
    check("rst_seg",      seg_data,    seg4(10, 10, 10, 10));
    check("rst_dp",       dp_data,     4'h0);
    check("rst_mode",     cur_mode,    2'd0);

    cyc(2);
    reset = 1'b0;
    cyc(1);
    check("first_seg",    seg_data,    seg4(10, 1, 10, 31));
    check("first_active", active,      4'h0);

    // 3-cycle glitch must be rejected
    btn_mode_raw = 1'b1;
    cyc(3);
    btn_mode_raw = 1'b0;
    cyc(10);
    check("glitch_mode",  cur_mode,    2'd0);

    press_mode();
    check("press1_mode",  cur_mode,    2'd1);
    check("press1_seg",   seg_data,    seg4(10, 2, 10, 31));
    press_mode();
    check("press2_mode",  cur_mode,    2'd2);
    press_mode();
    check("press3_mode",  cur_mode,    2'd3);
    press_mode();
    check("wrap_mode",    cur_mode,    2'd0);
    check("wrap_seg",     seg_data,    seg4(10, 1, 10, 31));

    press_mode();
    press_mode();
    check("sel2_mode",    cur_mode,    2'd2);
    check("sel2_seg",     seg_data,    seg4(10, 3, 10, 31));

    // Go press: debounced edge after 6 edges, GAP for 3, PLAY on the 10th
    btn_go_raw = 1'b1;
    cyc(9);
    check("gap_active",   active,      4'h0);
    check("gap_seg",      seg_data,    seg4(10, 3, 10, 31));
    cyc(1);
    check("play_active",  active,      4'b0100);
    check("play_led_lag", led,         16'h0000);
    check("play_go",      btn_go_stop, 1'b1);
    cyc(1);
    check("play_led",     led,         16'hA5C3);
    check("play_seg",     seg_data,    20'hABCDE);
    check("play_dp",      dp_data,     4'h4);

    mode_led[47:32] = 16'h5A3C;
    mode_led[31:16] = 16'hFFFF;
    cyc(1);
    check("play_led_upd", led,         16'h5A3C);

    btn_go_raw = 1'b0;
    cyc(10);
    check("play_go_rel",  btn_go_stop, 1'b0);
    check("play_stay0",   active,      4'b0100);
    btn_go_raw = 1'b1;
    cyc(10);
    check("play_go_again", active,     4'b0100);
    check("play_go_lvl",  btn_go_stop, 1'b1);

    // Mode press in PLAY with go still held
    btn_mode_raw = 1'b1;
    cyc(6);
    check("exit_pre_act", active,      4'b0100);
    check("exit_pre_go",  btn_go_stop, 1'b1);
    cyc(1);
    check("exit_active",  active,      4'h0);
    check("exit_go",      btn_go_stop, 1'b0);
    cyc(3);
    btn_mode_raw = 1'b0;
    btn_go_raw   = 1'b0;
    cyc(10);
    check("exit_mode",    cur_mode,    2'd2);
    check("exit_seg",     seg_data,    seg4(10, 3, 10, 31));
    check("exit_led",     led,         16'h0000);

    // Coincident debounced mode and go edges in MENU
    btn_mode_raw = 1'b1;
    btn_go_raw   = 1'b1;
    cyc(12);
    check("simul_active", active,      4'h0);
    btn_mode_raw = 1'b0;
    btn_go_raw   = 1'b0;
    cyc(10);
    check("simul_mode",   cur_mode,    2'd3);
    check("simul_act2",   active,      4'h0);
    check("simul_seg",    seg_data,    seg4(10, 4, 10, 31));

    // Abort: reset mid-PLAY, observed before any clock edge
    btn_go_raw = 1'b1;
    cyc(10);
    check("abort_play",   active,      4'b1000);
    cyc(2);
    #2 reset = 1'b1;
    #1;
    check("abort_active", active,      4'h0);
    check("abort_seg",    seg_data,    seg4(10, 10, 10, 10));
    check("abort_mode",   cur_mode,    2'd0);
    check("abort_go",     btn_go_stop, 1'b0);
    btn_go_raw = 1'b0;
    cyc(2);
    reset = 1'b0;
    cyc(2);

`ifdef WIN_TALLY_EN
    btn_go_raw = 1'b1;
    cyc(12);
    check("tally_play",   active,      4'b0001);
    btn_go_raw = 1'b0;
    cyc(10);
    for (int i = 0; i < 11; i++) begin
      mode_win[0] = 1'b1;
      cyc(1);
      mode_win[0] = 1'b0;
      cyc(1);
    end
    press_mode();
    check("tally_seg",    seg_data,    seg4(10, 1, 10, 9));
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
